mod10_counter: RTL and testbench
================================

Name: mod10_counter

Overview:
- Synchronous 4-bit decade counter. Counts up or down, wrapping within 0..9, with parallel load.
- Used as the counting element in the counter subsystem and as the DUT for the mod-10 verification environment.
- The bench drives `rst`, `load`, `mode` and `data_in`, and observes `data_out` on rising edges of `clock`.

Parameters:
- MOD, 10, counting modulus; the count range is 0..MOD-1.
- WIDTH, 4, width of `data_in` and `data_out`; must satisfy 2^WIDTH >= MOD.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  synchronous parallel-load enable.
- mode  input  1  count direction: 1 = up, 0 = down.
- data_in  input  WIDTH  parallel-load value.
- data_out  output  WIDTH  current count; registered output.

Interface (already decided):
- One clock, `clock`.
- Reset `rst` is asynchronous and active-high.

Behaviour:
- Reset:
  - `rst` high forces `data_out` = 0 immediately, with no clock edge needed.
  - `data_out` stays 0 while `rst` is high.
  - Counting resumes on the first rising edge after `rst` deasserts; that edge applies `load`/`mode` normally.
- Priority on each rising edge: `rst` > `load` > count.
- Load (`load` = 1):
  - If `data_in` <= MOD-1, `data_out` <= `data_in`.
  - If `data_in` >= MOD (10..15), `data_out` <= 0.
  - `mode` is ignored on a load cycle.
- Up count (`load` = 0, `mode` = 1):
  - `data_out` <= `data_out` + 1.
  - Wraps 9 -> 0.
- Down count (`load` = 0, `mode` = 0):
  - `data_out` <= `data_out` - 1.
  - Wraps 0 -> 9.
- No hold state: with `rst` = 0 and `load` = 0, the counter advances on every edge.
- Latency:
  - Inputs are sampled at rising edge N; the result is visible on `data_out` after edge N.
  - A reference model predicts `data_out` after edge N from the inputs at edge N and `data_out` before edge N.
- Range invariant: `data_out` never leaves 0..MOD-1, whatever the stimulus.
- Direction change: takes effect on the next edge, with no dead cycle. Example: `data_out` = 5, `mode` flips 1 -> 0 -> result 4.
- Reset mid-operation:
  - Any in-progress count sequence is abandoned.
  - A simultaneous `load` is ignored while `rst` is high.
- X/Z on `load` or `mode` while out of reset is illegal stimulus. The design must not be required to resolve it.

Test Plan:
- Reset: assert `rst` between clock edges -> `data_out` = 0 without waiting for an edge. Deassert, then `mode` = 1 for 3 edges -> 1, 2, 3.
- Up wrap: load 7, then `mode` = 1 for 4 edges -> 8, 9, 0, 1.
- Down wrap: load 2, then `mode` = 0 for 4 edges -> 1, 0, 9, 8.
- Load priority and range:
  - `load` = 1, `data_in` = 6, `mode` = 0 -> 6.
  - `load` = 1, `data_in` = 12 -> 0.
  - `load` = 1, `data_in` = 9, `mode` = 1 -> 9, then next up edge -> 0.
- Direction change and reset-over-load:
  - Count up to 5, flip `mode` to 0 -> 4, 3.
  - Then `rst` = 1 with `load` = 1, `data_in` = 8 -> `data_out` stays 0.
- Random regression: 1000 cycles of random `rst` (5%), `load` (20%), `mode`, `data_in` 0..15 -> `data_out` always matches the reference model and stays <= 9.

Source files
------------

// File: rtl/mod10_counter.sv
// Decade up/down counter with parallel load, asynchronous active-high reset.
// Count stays within 0..MOD-1; out-of-range load values land on 0.
module mod10_counter #(
  parameter int MOD   = 10,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  if ((2 ** WIDTH) < MOD) begin : g_width_check
    $error("mod10_counter: WIDTH too small for MOD");
  end

  logic [WIDTH-1:0] next_count;

  // The >= / > guards keep the count inside 0..MAX even from an illegal state.
  always_comb begin
    next_count = data_out;
    if (load) begin
      next_count = (data_in <= MAX) ? data_in : '0;
    end else if (mode) begin
      next_count = (data_out >= MAX) ? '0 : data_out + 1'b1;
    end else begin
      next_count = ((data_out == '0) || (data_out > MAX)) ? MAX : data_out - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= next_count;
    end
  end

endmodule

// File: tb/tb_mod10_counter.sv
// Self-checking bench for mod10_counter: directed vectors with hand-computed
// results, then a short randomized run against a modulo-arithmetic model.
module tb_mod10_counter;

  logic       clock;
  logic       rst;
  logic       load;
  logic       mode;
  logic [3:0] data_in;
  logic [3:0] data_out;

  int errors = 0;
  int checks = 0;

  mod10_counter #(.MOD(10), .WIDTH(4)) dut (
    .clock    (clock),
    .rst      (rst),
    .load     (load),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val, input logic m, input logic [3:0] exp, input string tag);
    load = 1'b1; mode = m; data_in = val;
    step();
    check(tag, data_out, exp);
    load = 1'b0;
  endtask

  task automatic count_seq(input logic m, input int n, input logic [3:0] e0,
                           input logic [3:0] e1, input logic [3:0] e2,
                           input logic [3:0] e3, input string tag);
    logic [3:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    load = 1'b0; mode = m;
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s[%0d]", tag, i), data_out, exp[i]);
    end
  endtask

  logic [3:0] model;
  logic       r_rst, r_load, r_mode;
  logic [3:0] r_din;

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b1; data_in = 4'd0;
    #3;
    check("reset_async_init", data_out, 4'd0);
    repeat (2) step();
    check("reset_held", data_out, 4'd0);

    rst = 1'b0;
    count_seq(1'b1, 3, 4'd1, 4'd2, 4'd3, 4'd0, "after_reset_up");

    // Async reset between edges, no clock edge needed.
    rst = 1'b1;
    #2;
    check("reset_async_mid", data_out, 4'd0);
    step();
    rst = 1'b0;

    do_load(4'd7, 1'b1, 4'd7, "load7");
    count_seq(1'b1, 4, 4'd8, 4'd9, 4'd0, 4'd1, "up_wrap");

    do_load(4'd2, 1'b0, 4'd2, "load2");
    count_seq(1'b0, 4, 4'd1, 4'd0, 4'd9, 4'd8, "down_wrap");

    do_load(4'd6, 1'b0, 4'd6, "load6_mode0");
    do_load(4'd12, 1'b1, 4'd0, "load12_range");
    do_load(4'd15, 1'b0, 4'd0, "load15_range");
    do_load(4'd9, 1'b1, 4'd9, "load9");
    count_seq(1'b1, 1, 4'd0, 4'd0, 4'd0, 4'd0, "up_from9");

    do_load(4'd3, 1'b1, 4'd3, "load3");
    count_seq(1'b1, 2, 4'd4, 4'd5, 4'd0, 4'd0, "up_to5");
    count_seq(1'b0, 2, 4'd4, 4'd3, 4'd0, 4'd0, "dir_flip");

    // Reset wins over a simultaneous load.
    rst = 1'b1; load = 1'b1; data_in = 4'd8;
    #2;
    check("rst_over_load_async", data_out, 4'd0);
    step();
    check("rst_over_load_edge", data_out, 4'd0);
    rst = 1'b0; load = 1'b0; mode = 1'b1;
    step();
    check("resume_after_rst", data_out, 4'd1);

    // Randomized regression against a modulo model.
    model = data_out;
    for (int i = 0; i < 1000; i++) begin
      r_rst  = ($urandom_range(99) < 5);
      r_load = ($urandom_range(99) < 20);
      r_mode = 1'($urandom_range(1));
      r_din  = 4'($urandom_range(15));
      rst = r_rst; load = r_load; mode = r_mode; data_in = r_din;
      if (r_rst)       model = 4'd0;
      else if (r_load) model = (r_din < 4'd10) ? r_din : 4'd0;
      else if (r_mode) model = 4'((int'(model) + 1) % 10);
      else             model = 4'((int'(model) + 9) % 10);
      step();
      check($sformatf("rand[%0d]", i), data_out, model);
      check($sformatf("range[%0d]", i), {3'b000, (data_out <= 4'd9)}, 4'd1);
    end
    rst = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
